// File: rtl/m_pipereg_skid.sv
// E-to-M pipeline register with a one-entry skid buffer, so in_ready can be a
// function of registered state only while still sustaining one entry per cycle.
module m_pipereg_skid #(
  parameter int              DW       = 32,
  parameter int              NSRC     = 2,
  parameter int              SELW     = 1,
  parameter logic [DW-1:0]   RESET_PC = DW'(32'h00003000),
  parameter int              CW       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        ir_e,
  input  logic [DW-1:0]        pc4_e,
  input  logic [DW-1:0]        rs_e,
  input  logic [DW-1:0]        rt_e,
  input  logic [NSRC*DW-1:0]   src_bus,
  input  logic [SELW-1:0]      src_sel,
  input  logic                 br_true_e,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        ir_m,
  output logic [DW-1:0]        pc4_m,
  output logic [DW-1:0]        pc8_m,
  output logic [DW-1:0]        ao_m,
  output logic [DW-1:0]        rs_m,
  output logic [DW-1:0]        rt_m,
  output logic                 br_true_m,
  output logic [CW-1:0]        stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] ir;
    logic [DW-1:0] pc4;
    logic [DW-1:0] pc8;
    logic [DW-1:0] ao;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic          br;
  } entry_t;

  localparam entry_t BUBBLE = '{
    ir:  '0,
    pc4: RESET_PC + DW'(4),
    pc8: RESET_PC + DW'(8),
    ao:  '0,
    rs:  '0,
    rt:  '0,
    br:  1'b0
  };

  state_t        state_q, state_d;
  entry_t        main_q, main_d;
  entry_t        skid_q, skid_d;
  entry_t        cap;
  logic [CW-1:0] stall_q, stall_d;
  logic          in_fire;
  logic          main_ld_in, main_ld_skid, main_clr, skid_ld_in;

  // Unused select codes (>= NSRC) alias source 0, so the mux needs no range check.
  logic [DW-1:0] src_arr [2**SELW];
  genvar gi;
  generate
    for (gi = 0; gi < 2**SELW; gi++) begin : g_src
      if (gi < NSRC) begin : g_real
        assign src_arr[gi] = src_bus[gi*DW +: DW];
      end else begin : g_alias
        assign src_arr[gi] = src_bus[DW-1:0];
      end
    end
  endgenerate

  always_comb begin
    cap     = BUBBLE;
    cap.ir  = ir_e;
    cap.pc4 = pc4_e;
    cap.pc8 = pc4_e + DW'(4);
    cap.ao  = src_arr[src_sel];
    cap.rs  = rs_e;
    cap.rt  = rt_e;
    cap.br  = br_true_e;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (in_fire) state_d = S_ONE;
        S_ONE: begin
          if (in_fire && !out_ready)      state_d = S_FULL;
          else if (!in_fire && out_ready) state_d = S_EMPTY;
        end
        S_FULL:  if (out_ready) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // FSM: outputs and datapath load strobes
  always_comb begin
    in_ready     = (state_q != S_FULL);
    out_valid    = (state_q != S_EMPTY);
    in_fire      = in_valid & in_ready;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    main_clr     = 1'b0;
    skid_ld_in   = 1'b0;
    case (state_q)
      S_EMPTY: main_ld_in = in_fire;
      S_ONE: begin
        main_ld_in = in_fire & out_ready;
        skid_ld_in = in_fire & !out_ready;
        main_clr   = !in_fire & out_ready;
      end
      S_FULL:  main_ld_skid = out_ready;
      default: main_clr = 1'b1;
    endcase
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = BUBBLE;
      skid_d = BUBBLE;
    end else begin
      if (main_ld_in)        main_d = cap;
      else if (main_ld_skid) main_d = skid_q;
      else if (main_clr)     main_d = BUBBLE;
      if (skid_ld_in)        skid_d = cap;
    end
  end

  // Counts every stalled-valid cycle, including one coinciding with flush.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CW{1'b1}}))
      stall_d = stall_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      stall_q <= '0;
    end else begin
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign ir_m      = main_q.ir;
  assign pc4_m     = main_q.pc4;
  assign pc8_m     = main_q.pc8;
  assign ao_m      = main_q.ao;
  assign rs_m      = main_q.rs;
  assign rt_m      = main_q.rt;
  assign br_true_m = main_q.br;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_m_pipereg_skid.sv
// Directed bench for m_pipereg_skid: a default instance plus an NSRC=3/CW=2
// instance sharing the same handshake stimulus.
module tb_m_pipereg_skid;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, br_true_e;
  logic [31:0] ir_e, pc4_e, rs_e, rt_e;
  logic [63:0] src_bus;
  logic [0:0]  src_sel;
  logic [95:0] src_bus3;
  logic [1:0]  src_sel3;

  logic        in_ready, out_valid, br_true_m;
  logic [31:0] ir_m, pc4_m, pc8_m, ao_m, rs_m, rt_m;
  logic [15:0] stall_cnt;

  logic        in_ready3, out_valid3, br_true_m3;
  logic [31:0] ir_m3, pc4_m3, pc8_m3, ao_m3, rs_m3, rt_m3;
  logic [1:0]  stall_cnt3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  m_pipereg_skid u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ir_e(ir_e), .pc4_e(pc4_e), .rs_e(rs_e), .rt_e(rt_e),
    .src_bus(src_bus), .src_sel(src_sel), .br_true_e(br_true_e),
    .out_valid(out_valid), .out_ready(out_ready),
    .ir_m(ir_m), .pc4_m(pc4_m), .pc8_m(pc8_m), .ao_m(ao_m),
    .rs_m(rs_m), .rt_m(rt_m), .br_true_m(br_true_m), .stall_cnt(stall_cnt)
  );

  m_pipereg_skid #(.DW(32), .NSRC(3), .SELW(2), .CW(2)) u_dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3),
    .ir_e(ir_e), .pc4_e(pc4_e), .rs_e(rs_e), .rt_e(rt_e),
    .src_bus(src_bus3), .src_sel(src_sel3), .br_true_e(br_true_e),
    .out_valid(out_valid3), .out_ready(out_ready),
    .ir_m(ir_m3), .pc4_m(pc4_m3), .pc8_m(pc8_m3), .ao_m(ao_m3),
    .rs_m(rs_m3), .rt_m(rt_m3), .br_true_m(br_true_m3), .stall_cnt(stall_cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle before sampling.
  task automatic step(input string note);
    @(posedge clk);
    #1;
    $display("t=%0t %-14s in_ready=%0b out_valid=%0b ir_m=%08h pc8_m=%08h ao_m=%08h stall=%0d",
             $time, note, in_ready, out_valid, ir_m, pc8_m, ao_m, stall_cnt);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; br_true_e = 1'b0;
    ir_e = '0; pc4_e = '0; rs_e = '0; rt_e = '0;
    src_bus  = {32'h0000BBBB, 32'h0000AAAA};
    src_bus3 = {32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
    src_sel = 1'b0; src_sel3 = 2'd0;
    step("reset");
    step("reset");
    reset = 1'b1;
    step("idle");
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ir_m",      ir_m,  32'h0);
    chk("rst_pc4_m",     pc4_m, 32'h00003004);
    chk("rst_pc8_m",     pc8_m, 32'h00003008);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_stall",     {16'd0, stall_cnt}, 32'd0);

    // Unstalled stream: one-cycle latency, back-to-back
    out_ready = 1'b1; in_valid = 1'b1;
    ir_e = 32'h11; pc4_e = 32'h1004; rs_e = 32'h5; rt_e = 32'h6; br_true_e = 1'b1;
    src_sel = 1'b1; src_sel3 = 2'd1;
    step("stream_11");
    chk("s1_ir_m",  ir_m,  32'h11);
    chk("s1_pc8_m", pc8_m, 32'h1008);
    chk("s1_ao_sel1", ao_m, 32'hBBBB);
    chk("s1_rs_m",  rs_m,  32'h5);
    chk("s1_rt_m",  rt_m,  32'h6);
    chk("s1_br_m",  {31'd0, br_true_m}, 32'd1);
    chk("s1_valid", {31'd0, out_valid}, 32'd1);
    ir_e = 32'h22; pc4_e = 32'h1008; br_true_e = 1'b0; src_sel = 1'b0; src_sel3 = 2'd2;
    step("stream_22");
    chk("s2_ir_m",  ir_m,  32'h22);
    chk("s2_pc8_m", pc8_m, 32'h100C);
    chk("s2_ao_sel0", ao_m, 32'hAAAA);
    chk("s2_ao3_sel2", ao_m3, 32'hCCCC);
    chk("s2_br_m",  {31'd0, br_true_m}, 32'd0);
    chk("s2_valid", {31'd0, out_valid}, 32'd1);
    ir_e = 32'h33; pc4_e = 32'hFFFFFFFC; src_sel3 = 2'd3;
    step("stream_33");
    chk("s3_ir_m",  ir_m,  32'h33);
    chk("s3_pc8_wrap", pc8_m, 32'h0);
    chk("s3_ao3_sel3", ao_m3, 32'hAAAA);
    chk("s3_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step("drain");
    chk("dr_valid", {31'd0, out_valid}, 32'd0);
    chk("dr_ir_m",  ir_m,  32'h0);
    chk("dr_pc4_m", pc4_m, 32'h00003004);

    // Backpressure: fill main and skid, hold, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; ir_e = 32'h11; pc4_e = 32'h2004; src_sel = 1'b1;
    step("bp_11");
    chk("bp1_ir_m",  ir_m, 32'h11);
    chk("bp1_stall", {16'd0, stall_cnt}, 32'd0);
    ir_e = 32'h22; pc4_e = 32'h2008; src_sel = 1'b0;
    step("bp_22");
    chk("bp2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp2_ir_m",  ir_m, 32'h11);
    chk("bp2_stall", {16'd0, stall_cnt}, 32'd1);
    ir_e = 32'h44; pc4_e = 32'h5000; src_sel = 1'b1;
    step("bp_hold");
    chk("bp3_ir_m",  ir_m,  32'h11);
    chk("bp3_pc8_m", pc8_m, 32'h2008);
    chk("bp3_ao_m",  ao_m,  32'hBBBB);
    chk("bp3_stall", {16'd0, stall_cnt}, 32'd2);
    step("bp_hold");
    chk("bp4_stall",  {16'd0, stall_cnt},  32'd3);
    chk("bp4_stall3", {30'd0, stall_cnt3}, 32'd3);
    step("bp_hold");
    chk("bp5_stall",  {16'd0, stall_cnt},  32'd4);
    chk("bp5_stall3_sat", {30'd0, stall_cnt3}, 32'd3);
    in_valid = 1'b0; out_ready = 1'b1;
    step("bp_out_11");
    chk("bp6_ir_m",  ir_m,  32'h22);
    chk("bp6_pc8_m", pc8_m, 32'h200C);
    chk("bp6_ao_m",  ao_m,  32'hAAAA);
    chk("bp6_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp6_stall", {16'd0, stall_cnt}, 32'd4);
    step("bp_out_22");
    chk("bp7_valid", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with a live input: squash everything
    out_ready = 1'b0; in_valid = 1'b1; ir_e = 32'h55;
    step("fl_55");
    ir_e = 32'h66;
    step("fl_66");
    chk("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; ir_e = 32'h77;
    step("flush");
    chk("fl_valid",    {31'd0, out_valid}, 32'd0);
    chk("fl_ir_m",     ir_m, 32'h0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_stall_kept", {16'd0, stall_cnt}, 32'd6);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step("post_flush");
    chk("pf_valid", {31'd0, out_valid}, 32'd0);
    chk("pf_ir_m",  ir_m, 32'h0);

    // Reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; ir_e = 32'h88;
    step("rf_88");
    ir_e = 32'h99;
    step("rf_99");
    chk("rf_stall", {16'd0, stall_cnt}, 32'd7);
    reset = 1'b0;
    step("reset_full");
    chk("rf_valid",    {31'd0, out_valid}, 32'd0);
    chk("rf_ir_m",     ir_m, 32'h0);
    chk("rf_pc8_m",    pc8_m, 32'h00003008);
    chk("rf_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rf_stall0",   {16'd0, stall_cnt}, 32'd0);
    chk("rf_stall3_0", {30'd0, stall_cnt3}, 32'd0);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step("after_reset");
    chk("ar_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/m_pipereg_skid.md
M_PIPEREG_SKID -- requirements
Module: m_pipereg_skid

Interface
- REQ-001: Parameter DW, default 32, width of every datapath field.
- REQ-002: Parameter NSRC, default 2, number of candidate result sources (ALU, XALU, ...); legal range 1..8.
- REQ-003: Parameter SELW, default 1, width of the source-select field; SHALL satisfy 2^SELW >= NSRC.
- REQ-004: Parameter RESET_PC, default 32'h00003000, base PC used for reset and bubble values.
- REQ-005: Parameter CW, default 16, width of the stall counter.
- REQ-006: clk  in  1  the single clock; all state changes on its rising edge.
- REQ-007: reset  in  1  synchronous, active-low reset.
- REQ-008: flush  in  1  synchronous squash of all held entries.
- REQ-009: in_valid  in  1  upstream (E stage) presents an entry.
- REQ-010: in_ready  out  1  block accepts an entry this cycle; registered output.
- REQ-011: ir_e, pc4_e, rs_e, rt_e  in  DW each  instruction, PC+4, forwarded RS, forwarded RT.
- REQ-012: src_bus  in  NSRC*DW  packed result candidates; source k occupies bits [k*DW +: DW].
- REQ-013: src_sel  in  SELW  result source index.
- REQ-014: br_true_e  in  1  branch-taken flag.
- REQ-015: out_valid  out  1  M-stage entry valid.
- REQ-016: out_ready  in  1  downstream consumes the entry.
- REQ-017: ir_m, pc4_m, pc8_m, ao_m, rs_m, rt_m  out  DW each  M-stage fields.
- REQ-018: br_true_m  out  1  registered branch flag.
- REQ-019: stall_cnt  out  CW  saturating count of backpressure cycles.

Function
- REQ-020: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- REQ-021: Storage SHALL be a main entry (drives outputs) and one skid entry; occupancy states EMPTY, ONE, FULL.
- REQ-022: EMPTY: in_fire -> ONE, main loads the input.
- REQ-023: ONE: in_fire & out_ready -> ONE, main loads the input; in_fire & !out_ready -> FULL, skid loads the input; !in_fire & out_ready -> EMPTY.
- REQ-024: FULL: out_ready -> ONE, main loads skid; otherwise hold. in_fire cannot occur in FULL.
- REQ-025: in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, derived from registered state only.
- REQ-026: out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
- REQ-027: ao value captured = source src_sel of src_bus; src_sel >= NSRC SHALL select source 0.
- REQ-028: pc8 value captured = pc4_e + 4, modulo 2^DW; no pc8 input exists.
- REQ-029: ao, pc8 and the remaining fields SHALL be computed at capture time and stored, never recomputed from live inputs.
- REQ-030: Output fields SHALL hold unchanged while out_valid & !out_ready.
- REQ-031: In EMPTY, outputs SHALL show bubble values: ir_m 0, pc4_m RESET_PC+4, pc8_m RESET_PC+8, ao_m/rs_m/rt_m 0, br_true_m 0.
- REQ-032: flush = 1 (reset inactive) SHALL force EMPTY next cycle, load bubble values into main, discard skid, and ignore any in_fire that cycle.
- REQ-033: stall_cnt SHALL increment each cycle with out_valid & !out_ready, saturate at 2^CW-1, and not clear on flush.
- REQ-034: Latency input-to-output SHALL be exactly one cycle when unstalled; full throughput, one entry per cycle.
- REQ-035: Entry order SHALL be preserved; no entry duplicated or dropped except by flush.

Reset
- REQ-036: reset = 0 at a rising edge SHALL force EMPTY, bubble values on all fields, stall_cnt 0, in_ready 1 next cycle.
- REQ-037: Reset SHALL have priority over flush and all handshakes, including mid-FULL.
- REQ-038: No initial blocks; reset is the only initialisation.

Verification
- REQ-039: Reset then idle -> out_valid 0, ir_m 0, pc4_m 32'h00003004, pc8_m 32'h00003008, in_ready 1.
- REQ-040: Stream ir_e 0x11,0x22,0x33 with out_ready 1 -> each on ir_m one cycle later, pc8_m = pc4_e+4, out_valid continuous.
- REQ-041: out_ready 0, send 0x11 then 0x22 -> FULL, in_ready 0, ir_m holds 0x11, stall_cnt counts; out_ready 1 -> 0x11 then 0x22 emitted in order.
- REQ-042: src_bus = {0xBBBB, 0xAAAA}, src_sel 1 -> ao_m 0xBBBB; src_sel 0 -> 0xAAAA; NSRC=3, src_sel 3 -> source 0.
- REQ-043: FULL, flush 1 with in_valid 1 -> next cycle EMPTY, ir_m 0, in_ready 1, new input not captured.
- REQ-044: FULL, reset 0 for one cycle -> EMPTY, stall_cnt 0; CW=2 long stall -> stall_cnt saturates at 3.
